// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package regfile_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DRAIN = 2'd1,
    CLEAR      = 2'd2,
    DONE       = 2'd3
  } sched_state_e;

  localparam int unsigned FIFO_DEPTH = 2;

  // Write-port owner for the current cycle, highest priority first.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_CLEAR = 2'd1,
    SRC_WB    = 2'd2,
    SRC_FIFO  = 2'd3
  } wr_src_e;

endpackage

// File: rtl/mdu_wb_fifo.sv
// Two-entry FIFO holding MDU results ({addr,data}) until the write port is free.
module mdu_wb_fifo
  import regfile_sched_pkg::*;
#(
  parameter int unsigned PW = 37
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic [PW-1:0] head,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] mem [FIFO_DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between WB, buffered MDU results and
// a zeroing sweep; keeps a pending scoreboard for decode interlock.
module regfile_write_scheduler
  import regfile_sched_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [AW-1:0]    mdu_addr,
  input  logic [WIDTH-1:0] mdu_data,
  input  logic             mdu_issue,
  input  logic [AW-1:0]    mdu_issue_addr,
  input  logic [AW-1:0]    chk_addr1,
  input  logic [AW-1:0]    chk_addr2,
  output logic             chk_busy1,
  output logic             chk_busy2,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             err,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wdata
);

  localparam int unsigned PW = AW + WIDTH;

  sched_state_e     state;
  sched_state_e     state_next;
  wr_src_e          src;
  logic [AW-1:0]    counter;
  logic [DEPTH-1:0] sb;
  logic [DEPTH-1:0] sb_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [PW-1:0]    head;
  logic [AW-1:0]    head_addr;
  logic [WIDTH-1:0] head_data;
  logic             in_clear;
  logic             issue_busy;
  logic             err_set;

  assign {head_addr, head_data} = head;
  assign in_clear = (state == CLEAR);
  assign push     = mdu_valid && mdu_ready;
  assign pop      = (src == SRC_FIFO);

  mdu_wb_fifo #(.PW(PW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({mdu_addr, mdu_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (clr_start) state_next = WAIT_DRAIN;
      WAIT_DRAIN: if (fifo_empty && (sb == '0)) state_next = CLEAR;
      CLEAR:      if (counter == AW'(DEPTH - 1)) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // FSM outputs and write-port owner
  always_comb begin
    mdu_ready = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    src       = SRC_NONE;
    case (state)
      IDLE:       mdu_ready = !fifo_full;
      WAIT_DRAIN: clr_busy  = 1'b1;
      CLEAR:      clr_busy  = 1'b1;
      DONE:       clr_done  = 1'b1;
      default:    ;
    endcase
    if (in_clear)         src = SRC_CLEAR;
    else if (wb_we)       src = SRC_WB;
    else if (!fifo_empty) src = SRC_FIFO;
  end

  // Sweep address counter, parked at zero outside the sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         counter <= '0;
    else if (in_clear) counter <= counter + AW'(1);
    else               counter <= '0;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_addr;
    rf_wdata = wb_data;
    case (src)
      SRC_CLEAR: begin
        rf_we    = 1'b1;
        rf_waddr = counter;
        rf_wdata = '0;
      end
      SRC_WB:   rf_we = (wb_addr != '0);
      SRC_FIFO: begin
        rf_we    = (head_addr != '0);
        rf_waddr = head_addr;
        rf_wdata = head_data;
      end
      default: ;
    endcase
  end

  // A register retiring this very cycle is not treated as busy for a new issue
  assign issue_busy = sb[mdu_issue_addr] && !(pop && (head_addr == mdu_issue_addr));
  assign err_set    = (in_clear && (wb_we || mdu_issue)) ||
                      (!in_clear && mdu_issue && issue_busy);

  // Scoreboard: set wins over a same-cycle retire; bit 0 never set
  always_comb begin
    sb_next = sb;
    if (pop) sb_next[head_addr] = 1'b0;
    if (mdu_issue && !in_clear) sb_next[mdu_issue_addr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb  <= '0;
      err <= 1'b0;
    end else begin
      sb  <= sb_next;
      err <= err || err_set;
    end
  end

  assign chk_busy1 = sb[chk_addr1];
  assign chk_busy2 = sb[chk_addr2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a queue-based reference model.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        err;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_write_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .mdu_valid      (mdu_valid),
    .mdu_ready      (mdu_ready),
    .mdu_addr       (mdu_addr),
    .mdu_data       (mdu_data),
    .mdu_issue      (mdu_issue),
    .mdu_issue_addr (mdu_issue_addr),
    .chk_addr1      (chk_addr1),
    .chk_addr2      (chk_addr2),
    .chk_busy1      (chk_busy1),
    .chk_busy2      (chk_busy2),
    .clr_start      (clr_start),
    .clr_busy       (clr_busy),
    .clr_done       (clr_done),
    .err            (err),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, pending registers as a bit set,
  // clear progress as a phase (0 idle, 1 draining, 2 sweeping, 3 done) plus index.
  typedef struct {
    int          addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          mpend[32];
  int          mphase;
  int          midx;
  bit          merr;
  bit          ewe;
  int          eaddr;
  logic [31:0] edata;
  bit          eready;
  bit          popped;
  bit          pushed;
  bit          drained;
  int          ha;
  ent_t        ne;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      mphase = 0;
      midx   = 0;
      merr   = 1'b0;
    end
    ewe = 1'b0; eaddr = 0; edata = '0;
    if (mphase == 2) begin
      ewe = 1'b1; eaddr = midx; edata = '0;
    end else if (wb_we) begin
      ewe = (wb_addr != 5'd0); eaddr = int'(wb_addr); edata = wb_data;
    end else if (mq.size() > 0) begin
      ewe = (mq[0].addr != 0); eaddr = mq[0].addr; edata = mq[0].data;
    end
    eready = (mq.size() < 2) && (mphase == 0);
    chk("rf_we", 32'(rf_we), 32'(ewe));
    if (ewe) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(eaddr));
      chk("rf_wdata", rf_wdata, edata);
    end
    chk("mdu_ready", 32'(mdu_ready), 32'(eready));
    chk("chk_busy1", 32'(chk_busy1), 32'(mpend[chk_addr1]));
    chk("chk_busy2", 32'(chk_busy2), 32'(mpend[chk_addr2]));
    chk("clr_busy", 32'(clr_busy), 32'(mphase == 1 || mphase == 2));
    chk("clr_done", 32'(clr_done), 32'(mphase == 3));
    chk("err", 32'(err), 32'(merr));
    if (!reset) begin
      popped  = (mphase != 2) && !wb_we && (mq.size() > 0);
      ha      = popped ? mq[0].addr : -1;
      pushed  = mdu_valid && eready;
      drained = (mq.size() == 0);
      foreach (mpend[i]) if (mpend[i]) drained = 1'b0;
      if (mphase == 2 && (wb_we || mdu_issue)) merr = 1'b1;
      if (mphase != 2 && mdu_issue && mpend[mdu_issue_addr] && ha != int'(mdu_issue_addr))
        merr = 1'b1;
      if (popped) begin
        mpend[ha] = 1'b0;
        void'(mq.pop_front());
      end
      if (mdu_issue && mphase != 2 && mdu_issue_addr != 5'd0) mpend[mdu_issue_addr] = 1'b1;
      if (pushed) begin
        ne.addr = int'(mdu_addr);
        ne.data = mdu_data;
        mq.push_back(ne);
      end
      case (mphase)
        0: if (clr_start) mphase = 1;
        1: if (drained) begin mphase = 2; midx = 0; end
        2: if (midx == 31) mphase = 3; else midx++;
        default: mphase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    mdu_issue = 1'b0; mdu_issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;

    // Same-cycle WB write, then write to r0 suppressed
    tick();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; #1;
    chk("wb_we", 32'(rf_we), 32'd1);
    chk("wb_addr", 32'(rf_waddr), 32'd5);
    chk("wb_data", rf_wdata, 32'hDEADBEEF);
    tick(); wb_addr = 5'd0; #1;
    chk("wb_r0", 32'(rf_we), 32'd0);

    // Issue to r7, then result held behind three WB cycles
    tick(); wb_we = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd7; chk_addr1 = 5'd7;
    tick(); mdu_issue = 1'b0; #1;
    chk("busy7_set", 32'(chk_busy1), 32'd1);
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h1234;
    tick(); mdu_valid = 1'b0; wb_addr = 5'd2;
    tick(); wb_addr = 5'd3;
    tick(); wb_we = 1'b0; #1;
    chk("mdu7_addr", 32'(rf_waddr), 32'd7);
    chk("mdu7_data", rf_wdata, 32'h1234);
    chk("busy7_hold", 32'(chk_busy1), 32'd1);
    tick(); #1;
    chk("busy7_drop", 32'(chk_busy1), 32'd0);

    // Three pushes under continuous WB: FIFO fills, order preserved
    mdu_issue = 1'b1; mdu_issue_addr = 5'd10;
    tick(); mdu_issue_addr = 5'd11;
    tick(); mdu_issue_addr = 5'd12;
    tick(); mdu_issue = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'hAAAA0000;
    mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'h10; #1;
    chk("fill_ready0", 32'(mdu_ready), 32'd1);
    tick(); mdu_addr = 5'd11; mdu_data = 32'h11; #1;
    chk("fill_ready1", 32'(mdu_ready), 32'd1);
    tick(); mdu_addr = 5'd12; mdu_data = 32'h12; #1;
    chk("full_ready", 32'(mdu_ready), 32'd0);
    tick(); wb_we = 1'b0; #1;
    chk("drain0", 32'(rf_waddr), 32'd10);
    chk("drain0_data", rf_wdata, 32'h10);
    tick(); #1;
    chk("drain1", 32'(rf_waddr), 32'd11);
    chk("refill_ready", 32'(mdu_ready), 32'd1);
    tick(); mdu_valid = 1'b0; #1;
    chk("drain2", 32'(rf_waddr), 32'd12);
    chk("drain2_data", rf_wdata, 32'h12);

    // Issue and retire of r9 in the same cycle: bit stays set, no error
    tick(); mdu_issue = 1'b1; mdu_issue_addr = 5'd9; chk_addr1 = 5'd9;
    tick(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
    tick(); mdu_valid = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd9;
    tick(); mdu_issue = 1'b0; #1;
    chk("busy9_setwins", 32'(chk_busy1), 32'd1);
    chk("busy9_noerr", 32'(err), 32'd0);
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h999;
    tick(); mdu_valid = 1'b0;
    tick(); #1;
    chk("busy9_drop", 32'(chk_busy1), 32'd0);

    // Clear with one queued result and one outstanding op (pushed in the start cycle)
    mdu_issue = 1'b1; mdu_issue_addr = 5'd3; chk_addr2 = 5'd4;
    tick(); mdu_issue_addr = 5'd4;
    tick(); mdu_issue = 1'b0; wb_we = 1'b1; wb_addr = 5'd21; wb_data = 32'h21;
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h33;
    tick(); clr_start = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h44; #1;
    chk("clr_idle_busy", 32'(clr_busy), 32'd0);
    chk("clr_idle_ready", 32'(mdu_ready), 32'd1);
    tick(); clr_start = 1'b0; mdu_valid = 1'b0; wb_we = 1'b0; #1;
    chk("wd_busy", 32'(clr_busy), 32'd1);
    chk("wd_ready", 32'(mdu_ready), 32'd0);
    chk("wd_pop3", 32'(rf_waddr), 32'd3);
    tick(); #1;
    chk("wd_pop4", 32'(rf_waddr), 32'd4);
    chk("wd_busy4", 32'(chk_busy2), 32'd1);
    tick(); #1;
    chk("wd_idle_we", 32'(rf_we), 32'd0);
    chk("wd_busy4_drop", 32'(chk_busy2), 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick(); #1;
      chk("sweep_we", 32'(rf_we), 32'd1);
      chk("sweep_addr", 32'(rf_waddr), 32'(k));
      chk("sweep_data", rf_wdata, 32'd0);
    end
    tick(); #1;
    chk("done_pulse", 32'(clr_done), 32'd1);
    chk("done_busy", 32'(clr_busy), 32'd0);
    tick(); #1;
    chk("done_single", 32'(clr_done), 32'd0);

    // WB during sweep is dropped and sets sticky err; reset aborts sweep
    clr_start = 1'b1;
    tick(); clr_start = 1'b0;
    tick();
    tick();
    tick(); wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h66; #1;
    chk("drop_addr", 32'(rf_waddr), 32'd2);
    chk("drop_data", rf_wdata, 32'd0);
    chk("drop_err0", 32'(err), 32'd0);
    tick(); wb_we = 1'b0; #1;
    chk("err_set", 32'(err), 32'd1);
    repeat (4) tick();
    #1;
    chk("err_sticky", 32'(err), 32'd1);
    chk("sweep_busy", 32'(clr_busy), 32'd1);
    reset = 1'b1; #1;
    chk("abort_busy", 32'(clr_busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_ready", 32'(mdu_ready), 32'd1);
    tick(); reset = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
